pair_fifo: RTL and testbench
============================

# pair_fifo

Show-ahead FIFO holding (a, b) bit pairs in a reg array and feeding the two-input AND stage downstream: the head pair drives that stage's `a`/`b` inputs directly. It decouples the pair producer from the consumer, tracks occupancy and flags overflow/underflow attempts. Storage is a one-dimensional array of 2-bit entries, so no multi-dimensional port is needed.

## Interface
- `ADDR_W`, default 2: pointer width; depth `DEPTH = 2**ADDR_W`, so 4 entries by default. Must be ≥ 1.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `wr_en`  input  1  push request
- `wr_a`  input  1  a-bit of the pushed pair
- `wr_b`  input  1  b-bit of the pushed pair
- `rd_en`  input  1  pop request
- `rd_a`  output  1  head a-bit; 0 when empty
- `rd_b`  output  1  head b-bit; 0 when empty
- `full`  output  1  count == DEPTH
- `empty`  output  1  count == 0
- `count`  output  ADDR_W+1  occupancy, 0..DEPTH
- `ovf`  output  1  one-cycle pulse: a push was rejected
- `unf`  output  1  one-cycle pulse: a pop was rejected

## Operation
- **Storage:** `mem[0:DEPTH-1]` holds `{a,b}` entries. Pointers are `wr_ptr` and `rd_ptr`, each ADDR_W bits wide. The ADDR_W+1-bit `count` register is the single source of truth for full and empty.
- **Push accept:** `push = wr_en && (!full || pop)`. On accept, `mem[wr_ptr] <= {wr_a,wr_b}` and `wr_ptr <= wr_ptr+1`, wrapping modulo DEPTH through natural overflow.
- **Pop accept:** `pop = rd_en && !empty`. On accept, `rd_ptr <= rd_ptr+1`, also wrapping modulo DEPTH.
- **Count update:**
  - push only: count+1
  - pop only: count−1
  - both, or neither: count unchanged
- **Simultaneous push and pop:**
  - When full, both are accepted. The pop frees the slot the push fills; count stays DEPTH and `ovf` does not pulse.
  - When empty, the push is accepted and the pop is rejected. Count becomes 1 and `unf` pulses.
- **Head outputs (show-ahead):** `rd_a`/`rd_b` are combinational from `mem[rd_ptr]`, gated to 0 while `empty`. A pushed pair appears at the head in the cycle after the push edge.
- **Error flags:**
  - `ovf` is registered high for exactly one cycle after an edge where `wr_en && full && !pop`.
  - `unf` is registered high for exactly one cycle after an edge where `rd_en && empty`.
  - Rejected requests change no state other than these flags.
- **Reset:**
  - All of the following clear to 0 immediately, independent of `clk`: pointers, count, all mem entries, `ovf`, `unf`.
  - Resulting output values: `empty`=1, `full`=0, `count`=0, `rd_a`=`rd_b`=0.
  - Reset mid-operation discards stored data. The first accepted push after deassertion lands in `mem[0]`.

## Timing
- Write-to-head latency: 1 clock. A pair pushed at edge N is visible on `rd_a`/`rd_b` after edge N when the FIFO was empty.
- Pop effect: the head advances after the accepting edge. The consumer samples `rd_a`/`rd_b` before that edge, in the same cycle it asserts `rd_en`.
- `full`, `empty` and `count` change only on clock edges or on reset assertion.
- `ovf` and `unf` assert 1 cycle after the offending edge and last 1 cycle. Back-to-back offending requests hold the flag high continuously.
- No combinational path from `wr_en` or `rd_en` to any output.
- Pointer wrap: after DEPTH accepted pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Test plan
- **Reset:** assert `rst` mid-simulation with 3 entries stored → immediately `count`=0, `empty`=1, `rd_a`=`rd_b`=0. The next push of (1,1) appears at the head one cycle later.
- **Fill and overflow (ADDR_W=2):** push (0,1),(1,0),(1,1),(0,0) → `full`=1, `count`=4. Push (1,1) again → `ovf` pulses 1 cycle and `count` stays 4. Pop four times → heads read 01, 10, 11, 00 in order.
- **Underflow:** on an empty FIFO, pop → `unf` high 1 cycle, `count`=0, pointers unchanged.
- **Simultaneous push and pop when full:** FIFO full with 01,10,11,00; push (1,1) while popping → head becomes 10, `count`=4, no `ovf`. Drain the FIFO → order is 10, 11, 00, 11.
- **Simultaneous push and pop when empty:** push (1,1) while popping on an empty FIFO → `unf` pulses, `count`=1, head=11 on the next cycle.
- **Wrap and downstream:** stream 10 pairs with alternating push/pop while the AND stage is attached → its output equals `rd_a & rd_b` each cycle, the sequence matches input order across the pointer wrap, and `count` never exceeds 1.

Source files
------------

// File: rtl/pair_fifo.sv
// Show-ahead FIFO of (a, b) bit pairs; the head pair feeds a downstream AND stage.
// Occupancy lives in a single count register that alone decides full and empty.
module pair_fifo #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic              rd_en,
    output logic              rd_a,
    output logic              rd_b,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              unf
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        mem_r [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              ovf_r;
    logic              unf_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [1:0]        head_s;

    assign full_s  = (count_r == DEPTH_CNT);
    assign empty_s = (count_r == {(ADDR_W+1){1'b0}});
    // A pop on a full FIFO frees the slot the simultaneous push fills.
    assign pop_s   = rd_en && !empty_s;
    assign push_s  = wr_en && (!full_s || pop_s);
    assign head_s  = mem_r[rd_ptr_r];

    // Head pair shown ahead, forced to zero while nothing is stored.
    always_comb begin
        rd_a = 1'b0;
        rd_b = 1'b0;
        if (empty_s) begin
            rd_a = 1'b0;
            rd_b = 1'b0;
        end else begin
            rd_a = head_s[1];
            rd_b = head_s[0];
        end
    end

    // Storage array, cleared on reset so stale pairs never reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {wr_a, wr_b};
        end
    end

    // Pointers, occupancy and the one-cycle rejection flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            ovf_r <= wr_en && full_s && !pop_s;
            unf_r <= rd_en && empty_s;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: tb/tb_pair_fifo.sv
// Bench for pair_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_pair_fifo;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0, wr_a = 1'b0, wr_b = 1'b0, rd_en = 1'b0;
    logic          rd_a, rd_b, full, empty, ovf, unf;
    logic [AW:0]   count;
    logic          and_out;

    int total = 0;
    int bad   = 0;

    logic [1:0] q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    pair_fifo #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .rd_en(rd_en), .rd_a(rd_a), .rd_b(rd_b), .full(full), .empty(empty),
        .count(count), .ovf(ovf), .unf(unf)
    );

    // Downstream two-input AND stage fed by the head pair
    assign and_out = rd_a & rd_b;

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Every-cycle comparison against the queue model
    always @(negedge clk) begin
        logic [1:0] h;
        h = (q.size() > 0) ? q[0] : 2'b00;
        check("m_head", {rd_a, rd_b}, h);
        check("m_and", and_out, h[1] & h[0]);
        check("m_count", count, q.size());
        check("m_full", full, q.size() == DEPTH);
        check("m_empty", empty, q.size() == 0);
        check("m_ovf", ovf, exp_ovf);
        check("m_unf", unf, exp_unf);
    end

    // Drive one cycle; returns 1 time unit after the edge with the model updated
    task automatic cycle(input logic w, input logic a, input logic b, input logic r);
        bit fm, em, pm, wm;
        wr_en = w; wr_a = a; wr_b = b; rd_en = r;
        @(posedge clk);
        fm = (q.size() == DEPTH);
        em = (q.size() == 0);
        pm = r && !em;
        wm = w && (!fm || pm);
        exp_ovf = w && fm && !pm;
        exp_unf = r && em;
        if (pm) void'(q.pop_front());
        if (wm) q.push_back({a, b});
        #1;
        wr_en = 1'b0; rd_en = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (q.size() > 0) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] fill_pat [0:3];
        logic [1:0] d;
        fill_pat[0] = 2'b01; fill_pat[1] = 2'b10; fill_pat[2] = 2'b11; fill_pat[3] = 2'b00;

        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_head", {rd_a, rd_b}, 0);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Fill and overflow
        for (int i = 0; i < 4; i++) cycle(1'b1, fill_pat[i][1], fill_pat[i][0], 1'b0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovf_pulse", ovf, 1);
        check("ovf_count", count, 4);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_clear", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            check("pop_order", {rd_a, rd_b}, fill_pat[i]);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Underflow
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("unf_pulse", unf, 1);
        check("unf_count", count, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("unf_clear", unf, 0);

        // Push and pop together when full
        for (int i = 0; i < 4; i++) cycle(1'b1, fill_pat[i][1], fill_pat[i][0], 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("pp_full_head", {rd_a, rd_b}, 2);
        check("pp_full_count", count, 4);
        check("pp_full_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            d = (i == 3) ? 2'b11 : fill_pat[i + 1];
            check("pp_full_order", {rd_a, rd_b}, d);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Push and pop together when empty
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("pp_empty_unf", unf, 1);
        check("pp_empty_count", count, 1);
        check("pp_empty_head", {rd_a, rd_b}, 3);
        drain();

        // Reset with three entries stored
        for (int i = 0; i < 3; i++) cycle(1'b1, fill_pat[i][1], fill_pat[i][0], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_head", {rd_a, rd_b}, 0);
        q.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("post_rst_head", {rd_a, rd_b}, 3);
        check("post_rst_and", and_out, 1);
        drain();

        // Alternating stream across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            d = 2'($urandom_range(0, 3));
            cycle(1'b1, d[1], d[0], 1'b0);
            check("wrap_head", {rd_a, rd_b}, d);
            check("wrap_count_le1", count <= 1, 1);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check("wrap_count_le1", count <= 1, 1);
        end

        // Randomized soak with write-heavy then read-heavy phases
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 75 : 30;
            d = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 99) < wp), d[1], d[0], ($urandom_range(0, 99) < 50));
        end
        drain();

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
